// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pipe_pkg                                                       |
// | Shared control-bundle type and encodings for the RISC-V pipeline.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package riscv_pipe_pkg;

    localparam logic [1:0] RU_SRC_ALU = 2'b00;
    localparam logic [1:0] RU_SRC_DM  = 2'b01;
    localparam logic [1:0] RU_SRC_PC4 = 2'b10;
    localparam logic [4:0] BR_NONE    = 5'b00000;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] alu_a_src;
        logic       alu_b_src;
        logic       dm_write;
        logic [2:0] dm_ctrl;
        logic [4:0] br_op;
        logic [1:0] ru_data_src;
        logic       ru_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_op:      4'd0,
        alu_a_src:   2'd0,
        alu_b_src:   1'b0,
        dm_write:    1'b0,
        dm_ctrl:     3'd0,
        br_op:       BR_NONE,
        ru_data_src: RU_SRC_ALU,
        ru_write:    1'b0
    };

endpackage
`default_nettype wire

// File: rtl/de_ex_load_use_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | de_ex_load_use_detect                                                |
// | Combinational raw load-use compare between EX load and DE sources.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module de_ex_load_use_detect
    import riscv_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_valid_i,
    input  logic [1:0]            ex_ru_data_src_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  de_valid_i,
    input  logic                  rs1_used_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic                  rs2_used_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    output logic                  hazard_o
);

    logic w_ex_is_load;
    logic w_src_match;

    // x0 is never a real destination, so a load to x0 cannot create a hazard
    assign w_ex_is_load = ex_valid_i && (ex_ru_data_src_i == RU_SRC_DM) && (ex_rd_i != '0);
    assign w_src_match  = (rs1_used_i && (rs1_addr_i == ex_rd_i)) ||
                          (rs2_used_i && (rs2_addr_i == ex_rd_i));
    assign hazard_o     = w_ex_is_load && de_valid_i && w_src_match;

endmodule
`default_nettype wire

// File: rtl/de_ex_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | de_ex_pipe_reg                                                       |
// | DE->EX pipeline register with stall, flush, load-use bubble insertion|
// | and a saturating bubble counter.                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module de_ex_pipe_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic                  de_valid_in,
    input  logic [XLEN-1:0]       pc_in,
    input  logic [XLEN-1:0]       pc_plus4_in,
    input  logic [XLEN-1:0]       rs1_data_in,
    input  logic [XLEN-1:0]       rs2_data_in,
    input  logic [XLEN-1:0]       imm_in,
    input  logic [REG_ADDR_W-1:0] rs1_addr_in,
    input  logic [REG_ADDR_W-1:0] rs2_addr_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  rs1_used_in,
    input  logic                  rs2_used_in,
    input  ctrl_t                 ctrl_in,
    output logic                  ex_valid_out,
    output logic [XLEN-1:0]       pc_out,
    output logic [XLEN-1:0]       pc_plus4_out,
    output logic [XLEN-1:0]       rs1_data_out,
    output logic [XLEN-1:0]       rs2_data_out,
    output logic [XLEN-1:0]       imm_out,
    output logic [REG_ADDR_W-1:0] rs1_addr_out,
    output logic [REG_ADDR_W-1:0] rs2_addr_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output ctrl_t                 ctrl_out,
    output logic                  hazard_stall_out,
    output logic [CNT_W-1:0]      bubble_count_out
);

    logic                  valid_q,    valid_d;
    logic [XLEN-1:0]       pc_q,       pc_d;
    logic [XLEN-1:0]       pc4_q,      pc4_d;
    logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]       imm_q,      imm_d;
    logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;
    ctrl_t                 ctrl_q,     ctrl_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;

    logic w_raw_hazard;

    de_ex_load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lu_detect (
        .ex_valid_i       (valid_q),
        .ex_ru_data_src_i (ctrl_q.ru_data_src),
        .ex_rd_i          (rd_q),
        .de_valid_i       (de_valid_in),
        .rs1_used_i       (rs1_used_in),
        .rs1_addr_i       (rs1_addr_in),
        .rs2_used_i       (rs2_used_in),
        .rs2_addr_i       (rs2_addr_in),
        .hazard_o         (w_raw_hazard)
    );

    assign hazard_stall_out = w_raw_hazard && !flush_in && !stall_in;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        pc4_d      = pc4_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;

        if (stall_in) begin
            // hold: defaults already keep every register
        end else if (flush_in || hazard_stall_out) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            pc4_d      = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_d       = '0;
            ctrl_d     = CTRL_NOP;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d    = de_valid_in;
            pc_d       = pc_in;
            pc4_d      = pc_plus4_in;
            rs1_data_d = rs1_data_in;
            rs2_data_d = rs2_data_in;
            imm_d      = imm_in;
            rs1_addr_d = rs1_addr_in;
            rs2_addr_d = rs2_addr_in;
            rd_d       = rd_in;
            // an empty slot must never carry a write enable into EX
            ctrl_d     = de_valid_in ? ctrl_in : CTRL_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            pc4_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
            ctrl_q     <= CTRL_NOP;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid_out     = valid_q;
    assign pc_out           = pc_q;
    assign pc_plus4_out     = pc4_q;
    assign rs1_data_out     = rs1_data_q;
    assign rs2_data_out     = rs2_data_q;
    assign imm_out          = imm_q;
    assign rs1_addr_out     = rs1_addr_q;
    assign rs2_addr_out     = rs2_addr_q;
    assign rd_out           = rd_q;
    assign ctrl_out         = ctrl_q;
    assign bubble_count_out = cnt_q;

endmodule
`default_nettype wire
